// File: rtl/sram_readback_pkg.sv
// sram_readback_pkg
// Shared definitions for the result readback path:
//   - SRAM geometry constants shared with the writeback unit and sram_wrapper
//   - readback FSM state encoding (also exported on the debug state port)
//   - cnt_width(): width of a counter that must hold values 0..max_val
package sram_readback_pkg;

  localparam int SRAM_ADDR_W = 8;
  localparam int SRAM_DATA_W = 32;

  typedef enum logic [2:0] {
    RB_IDLE  = 3'd0,
    RB_REQ   = 3'd1,
    RB_WAIT  = 3'd2,
    RB_SHIFT = 3'd3,
    RB_DONE  = 3'd4
  } rb_state_e;

  // Never returns 0 so a counter for max_val=0 still has a legal vector width.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sram_readback_word_serializer.sv
// sram_readback_word_serializer
// Holds one captured SRAM word and emits it as OUT_W-bit slices, most
// significant slice first, under a valid/ready handshake.
//
// Handshake: a slice is transferred on every rising edge where
// dout_valid && dout_ready. While dout_valid && !dout_ready, dout is held
// stable. dout_valid drops after the last slice's transfer; a new word
// is only taken on load (no prefetch).
//
// Ports
//   clk, rst         clock, asynchronous active-low reset
//   clr              synchronous clear (abandoned pass), wins over load
//   load             capture word_in; dout_valid rises the next cycle
//   word_in          word to serialize
//   dout, dout_valid slice output and its valid flag
//   dout_ready       sink accepts the current slice
//   last_byte        the slice currently on dout is the final one of the word
module sram_readback_word_serializer
  import sram_readback_pkg::*;
#(
  parameter int DATA_W = SRAM_DATA_W,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] word_in,
  output logic [OUT_W-1:0]  dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              last_byte
);

  localparam int BYTES = DATA_W / OUT_W;
  localparam int CNT_W = cnt_width(BYTES - 1);

  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              xfer;

  assign xfer       = valid_q && dout_ready;
  assign last_byte  = valid_q && (cnt_q == CNT_W'(BYTES - 1));
  assign dout       = sh_q[DATA_W-1 -: OUT_W];
  assign dout_valid = valid_q;

  always_comb begin
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (clr) begin
      sh_d    = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else if (load) begin
      sh_d    = word_in;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (xfer) begin
      // Shifting left keeps the next slice in the top bits where dout reads it.
      sh_d = sh_q << OUT_W;
      if (last_byte) begin
        cnt_d   = '0;
        valid_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/sram_readback.sv
// sram_readback
// Reads NUM_WORDS result words from the result SRAM starting at BASE_ADDR
// and streams each one off-chip as OUT_W-bit bytes, MSB first.
//
// Sequence per word: REQ (address issued, cs_n low) -> WAIT (READ_LAT
// cycles, then until sram_ry) -> SHIFT (bytes out) -> REQ for the next
// word or DONE after the last one. rd_abort from any non-idle state
// returns to IDLE on the next edge without an rd_done pulse.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   rd_start, rd_abort        start pulse (IDLE only), abandon pass
//   rd_busy, rd_done          pass in progress, one-cycle completion pulse
//   sram_cs_n, sram_we_n      SRAM strobes (we_n constantly high: read only)
//   sram_address              word address
//   sram_ry, sram_read_data   SRAM ready and read data
//   dout, dout_valid, dout_ready  byte stream (valid/ready)
//   dbg_state                 current FSM state
module sram_readback
  import sram_readback_pkg::*;
#(
  parameter int               ADDR_W    = SRAM_ADDR_W,
  parameter int               DATA_W    = SRAM_DATA_W,
  parameter int               OUT_W     = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int               NUM_WORDS = 32,
  parameter int               READ_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_start,
  input  logic              rd_abort,
  output logic              rd_busy,
  output logic              rd_done,
  output logic              sram_cs_n,
  output logic              sram_we_n,
  output logic [ADDR_W-1:0] sram_address,
  input  logic              sram_ry,
  input  logic [DATA_W-1:0] sram_read_data,
  output logic [OUT_W-1:0]  dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output rb_state_e         dbg_state
);

  localparam int LAT_W = cnt_width(READ_LAT);

  rb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              ser_load;
  logic              ser_clr;
  logic              last_byte;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    word_d   = word_q;
    lat_d    = lat_q;
    ser_load = 1'b0;
    ser_clr  = 1'b0;
    if (state_q != RB_IDLE && rd_abort) begin
      state_d = RB_IDLE;
      addr_d  = '0;
      word_d  = '0;
      lat_d   = '0;
      ser_clr = 1'b1;
    end else begin
      case (state_q)
        RB_IDLE: begin
          // Abort alongside start keeps the block idle.
          if (rd_start && !rd_abort) begin
            state_d = RB_REQ;
            addr_d  = BASE_ADDR;
            word_d  = '0;
          end
        end
        RB_REQ: begin
          state_d = RB_WAIT;
          lat_d   = LAT_W'(READ_LAT);
        end
        RB_WAIT: begin
          // Latency must expire first; sram_ry then gates the capture.
          if (lat_q != '0) begin
            lat_d = lat_q - 1'b1;
          end else if (sram_ry) begin
            ser_load = 1'b1;
            state_d  = RB_SHIFT;
          end
        end
        RB_SHIFT: begin
          if (last_byte && dout_ready) begin
            if (word_q == ADDR_W'(NUM_WORDS - 1)) begin
              state_d = RB_DONE;
            end else begin
              state_d = RB_REQ;
              // Wraps modulo 2^ADDR_W by construction.
              addr_d  = addr_q + 1'b1;
              word_d  = word_q + 1'b1;
            end
          end
        end
        RB_DONE: begin
          state_d = RB_IDLE;
          addr_d  = '0;
          word_d  = '0;
        end
        default: state_d = RB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RB_IDLE;
      addr_q  <= '0;
      word_q  <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      lat_q   <= lat_d;
    end
  end

  assign rd_busy      = (state_q == RB_REQ) || (state_q == RB_WAIT) || (state_q == RB_SHIFT);
  assign rd_done      = (state_q == RB_DONE);
  assign sram_cs_n    = !((state_q == RB_REQ) || (state_q == RB_WAIT));
  assign sram_we_n    = 1'b1;
  assign sram_address = addr_q;
  assign dbg_state    = state_q;

  sram_readback_word_serializer #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W)
  ) u_ser (
    .clk        (clk),
    .rst        (rst),
    .clr        (ser_clr),
    .load       (ser_load),
    .word_in    (sram_read_data),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .last_byte  (last_byte)
  );

endmodule

// File: tb/tb_sram_readback.sv
module tb_sram_readback;
  import sram_readback_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_start;
  logic        rd_abort;
  logic        rd_busy;
  logic        rd_done;
  logic        sram_cs_n;
  logic        sram_we_n;
  logic [7:0]  sram_address;
  logic        sram_ry;
  logic [31:0] sram_read_data;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  rb_state_e   dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem [256];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  sram_readback #(
    .ADDR_W    (8),
    .DATA_W    (32),
    .OUT_W     (8),
    .BASE_ADDR (8'hFF),
    .NUM_WORDS (2),
    .READ_LAT  (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rd_start       (rd_start),
    .rd_abort       (rd_abort),
    .rd_busy        (rd_busy),
    .rd_done        (rd_done),
    .sram_cs_n      (sram_cs_n),
    .sram_we_n      (sram_we_n),
    .sram_address   (sram_address),
    .sram_ry        (sram_ry),
    .sram_read_data (sram_read_data),
    .dout           (dout),
    .dout_valid     (dout_valid),
    .dout_ready     (dout_ready),
    .dbg_state      (dbg_state)
  );

  // SRAM model: data for the selected address appears one cycle after issue.
  always @(posedge clk) begin
    if (!sram_cs_n) sram_read_data <= mem[sram_address];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a valid byte, compares it with the scoreboard head,
  // then steps one cycle so the byte is transferred (dout_ready assumed high).
  task automatic expect_byte(input string tag);
    int n;
    logic [31:0] exp;
    n = 0;
    while (!dout_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(dout_valid), 32'd1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    check(tag, 32'(dout), exp);
    @(negedge clk);
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_q.push_back(32'(w[31:24]));
    exp_q.push_back(32'(w[23:16]));
    exp_q.push_back(32'(w[15:8]));
    exp_q.push_back(32'(w[7:0]));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
    mem[8'hFF] = 32'h1122_3344;
    mem[8'h00] = 32'hA5A5_0F0F;
    sram_read_data = '0;
    rst = 1'b0; rd_start = 1'b0; rd_abort = 1'b0; sram_ry = 1'b1; dout_ready = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'(RB_IDLE));
    check("rst_busy", 32'(rd_busy), 32'd0);
    check("rst_done", 32'(rd_done), 32'd0);
    check("rst_cs_n", 32'(sram_cs_n), 32'd1);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_addr", 32'(sram_address), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // start together with abort in IDLE stays idle
    rd_start = 1'b1; rd_abort = 1'b1;
    @(negedge clk);
    rd_start = 1'b0; rd_abort = 1'b0;
    check("start_abort_idle", 32'(dbg_state), 32'(RB_IDLE));
    check("start_abort_cs_n", 32'(sram_cs_n), 32'd1);

    // pass 1: full readback with ry stall, backpressure and address wrap
    push_word(32'h1122_3344);
    push_word(32'hA5A5_0F0F);
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    check("req_state", 32'(dbg_state), 32'(RB_REQ));
    check("req_addr", 32'(sram_address), 32'hFF);
    check("req_cs_n", 32'(sram_cs_n), 32'd0);
    check("req_busy", 32'(rd_busy), 32'd1);
    @(negedge clk);
    check("wait_state", 32'(dbg_state), 32'(RB_WAIT));
    sram_ry = 1'b0;
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_state", 32'(dbg_state), 32'(RB_WAIT));
      check("stall_cs_n", 32'(sram_cs_n), 32'd0);
      check("stall_addr", 32'(sram_address), 32'hFF);
      check("stall_valid", 32'(dout_valid), 32'd0);
    end
    sram_ry = 1'b1;
    @(negedge clk);
    check("capture_first_ry", 32'(dbg_state), 32'(RB_SHIFT));
    expect_byte("p1_b0");
    // backpressure while byte 0x22 is offered
    dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_dout", 32'(dout), 32'h22);
      check("bp_valid", 32'(dout_valid), 32'd1);
      @(negedge clk);
    end
    dout_ready = 1'b1;
    expect_byte("p1_b1");
    expect_byte("p1_b2");
    expect_byte("p1_b3");
    check("gap_valid", 32'(dout_valid), 32'd0);
    check("gap_state", 32'(dbg_state), 32'(RB_REQ));
    check("wrap_addr", 32'(sram_address), 32'h00);
    check("wrap_cs_n", 32'(sram_cs_n), 32'd0);
    expect_byte("p1_b4");
    expect_byte("p1_b5");
    expect_byte("p1_b6");
    expect_byte("p1_b7");
    check("done_pulse", 32'(rd_done), 32'd1);
    check("done_busy", 32'(rd_busy), 32'd0);
    check("done_cs_n", 32'(sram_cs_n), 32'd1);
    check("done_valid", 32'(dout_valid), 32'd0);
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    check("done_one_cycle", 32'(rd_done), 32'd0);
    check("start_in_done_ignored", 32'(dbg_state), 32'(RB_IDLE));
    @(negedge clk);
    check("idle_after_done", 32'(rd_busy), 32'd0);

    // pass 2: start while busy ignored, abort after the 3rd byte
    push_word(32'h1122_3344);
    void'(exp_q.pop_back());
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    expect_byte("p2_b0");
    rd_start = 1'b1;
    expect_byte("p2_b1");
    rd_start = 1'b0;
    expect_byte("p2_b2");
    check("no_restart_dout", 32'(dout), 32'h44);
    rd_abort = 1'b1;
    @(negedge clk);
    rd_abort = 1'b0;
    check("abort_state", 32'(dbg_state), 32'(RB_IDLE));
    check("abort_valid", 32'(dout_valid), 32'd0);
    check("abort_cs_n", 32'(sram_cs_n), 32'd1);
    check("abort_busy", 32'(rd_busy), 32'd0);
    check("abort_no_done", 32'(rd_done), 32'd0);
    @(negedge clk);
    check("abort_no_done_later", 32'(rd_done), 32'd0);

    // pass 3: restart from BASE_ADDR, then async reset mid-SHIFT
    push_word(32'h1122_3344);
    exp_q.push_back(32'hA5);
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    check("restart_addr", 32'(sram_address), 32'hFF);
    check("restart_state", 32'(dbg_state), 32'(RB_REQ));
    expect_byte("p3_b0");
    expect_byte("p3_b1");
    expect_byte("p3_b2");
    expect_byte("p3_b3");
    expect_byte("p3_b4");
    check("pre_rst_shift", 32'(dbg_state), 32'(RB_SHIFT));
    #2;
    rst = 1'b0;
    #1;
    check("arst_state", 32'(dbg_state), 32'(RB_IDLE));
    check("arst_valid", 32'(dout_valid), 32'd0);
    check("arst_dout", 32'(dout), 32'd0);
    check("arst_cs_n", 32'(sram_cs_n), 32'd1);
    check("arst_busy", 32'(rd_busy), 32'd0);
    check("arst_addr", 32'(sram_address), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("post_rst_idle", 32'(dbg_state), 32'(RB_IDLE));

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
